// File: rtl/monster_march_ctrl.sv
// monster_march_ctrl: sequences the monster formation.
// Holds the formation origin and march direction. Steps the formation once every `period`
// frame ticks, where the period shrinks as columns die. At a screen edge the formation drops
// one row and reverses. Reports landing or a cleared formation to the game state machine.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start        one-cycle pulse, loads the formation for level_in (any state)
//   level_in     level select: 2 gives PERIOD_L2, anything else gives PERIOD_L1
//   frame_tick   one pulse per video frame
//   freeze       hold the frame counter and position
//   alive_mask   bit i set while column i has a live monster
//   form_x/y     formation origin (left pixel of column 0, top row)
//   dir          0 = moving right, 1 = moving left
//   step_pulse   one-cycle pulse after each position update
//   landed       sticky, formation reached Y_LIMIT
//   cleared      sticky, alive_mask went to zero while marching
//   busy         high while marching
module monster_march_ctrl #(
   parameter int unsigned COLS       = 8,
   parameter int unsigned COL_W      = 40,
   parameter int unsigned MON_W      = 32,
   parameter int unsigned X_MIN      = 144,
   parameter int unsigned X_MAX      = 783,
   parameter int unsigned X_START    = 160,
   parameter int unsigned Y_START    = 75,
   parameter int unsigned STEP_X     = 4,
   parameter int unsigned STEP_Y     = 16,
   parameter int unsigned Y_LIMIT    = 400,
   parameter int unsigned PERIOD_L1  = 30,
   parameter int unsigned PERIOD_L2  = 15,
   parameter int unsigned MIN_PERIOD = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      level_in,
   input  logic            frame_tick,
   input  logic            freeze,
   input  logic [COLS-1:0] alive_mask,
   output logic [9:0]      form_x,
   output logic [9:0]      form_y,
   output logic            dir,
   output logic            step_pulse,
   output logic            landed,
   output logic            cleared,
   output logic            busy
);

   localparam int unsigned ColW = (COLS > 1) ? $clog2(COLS) : 1;

   typedef enum logic [1:0] {StIdle, StLoad, StMarch, StHalt} state_e;

   state_e      state_q, state_d;
   logic [9:0]  x_q, x_d;
   logic [9:0]  y_q, y_d;
   logic        dir_q, dir_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [7:0]  base_q, base_d;
   logic        pulse_q, pulse_d;
   logic        landed_q, landed_d;
   logic        cleared_q, cleared_d;

   logic [7:0]      n_alive;
   logic [7:0]      dead;
   logic [7:0]      period;
   logic            step_due;
   logic [ColW-1:0] lcol, rcol;
   logic [10:0]     left_px, right_px;
   logic            hit_left, hit_right;

   // Step period: base minus dead columns, clamped, re-evaluated every cycle.
   always_comb begin
      n_alive = '0;
      for (int i = 0; i < int'(COLS); i++) begin
         n_alive = n_alive + 8'(alive_mask[i]);
      end
      dead = 8'(COLS) - n_alive;
      if (base_q >= dead + 8'(MIN_PERIOD)) begin
         period = base_q - dead;
      end else begin
         period = 8'(MIN_PERIOD);
      end
      // >= rather than == so a period that shrinks mid-count still fires
      step_due = (cnt_q >= period - 8'd1);
   end

   // Outermost live columns and their pixel extents.
   always_comb begin
      lcol = '0;
      rcol = '0;
      for (int i = int'(COLS) - 1; i >= 0; i--) begin
         if (alive_mask[i]) lcol = i[ColW-1:0];
      end
      for (int i = 0; i < int'(COLS); i++) begin
         if (alive_mask[i]) rcol = i[ColW-1:0];
      end
      left_px   = {1'b0, x_q} + 11'(lcol) * 11'(COL_W);
      right_px  = {1'b0, x_q} + 11'(rcol) * 11'(COL_W) + 11'(MON_W - 1);
      hit_right = (right_px + 11'(STEP_X)) > 11'(X_MAX);
      hit_left  = left_px < 11'(X_MIN + STEP_X);
   end

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      dir_d     = dir_q;
      cnt_d     = cnt_q;
      base_d    = base_q;
      pulse_d   = 1'b0;
      landed_d  = landed_q;
      cleared_d = cleared_q;

      if (start) begin
         // Formation is loaded on the edge that enters LOAD so the origin is
         // already valid during the LOAD cycle.
         state_d   = StLoad;
         x_d       = 10'(X_START);
         y_d       = 10'(Y_START);
         dir_d     = 1'b0;
         cnt_d     = '0;
         landed_d  = 1'b0;
         cleared_d = 1'b0;
         base_d    = (level_in == 3'd2) ? 8'(PERIOD_L2) : 8'(PERIOD_L1);
      end else begin
         case (state_q)
            StIdle: ;
            StLoad: state_d = StMarch;
            StMarch: begin
               if (alive_mask == '0) begin
                  cleared_d = 1'b1;
                  state_d   = StHalt;
               end else if (y_q >= 10'(Y_LIMIT)) begin
                  landed_d = 1'b1;
                  state_d  = StHalt;
               end else if (frame_tick && !freeze) begin
                  if (step_due) begin
                     cnt_d   = '0;
                     pulse_d = 1'b1;
                     if (dir_q ? hit_left : hit_right) begin
                        y_d   = y_q + 10'(STEP_Y);
                        dir_d = ~dir_q;
                     end else if (dir_q) begin
                        x_d = x_q - 10'(STEP_X);
                     end else begin
                        x_d = x_q + 10'(STEP_X);
                     end
                  end else begin
                     cnt_d = cnt_q + 8'd1;
                  end
               end
            end
            StHalt: ;
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         x_q       <= 10'(X_START);
         y_q       <= 10'(Y_START);
         dir_q     <= 1'b0;
         cnt_q     <= '0;
         base_q    <= 8'(PERIOD_L1);
         pulse_q   <= 1'b0;
         landed_q  <= 1'b0;
         cleared_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         dir_q     <= dir_d;
         cnt_q     <= cnt_d;
         base_q    <= base_d;
         pulse_q   <= pulse_d;
         landed_q  <= landed_d;
         cleared_q <= cleared_d;
      end
   end

   assign form_x     = x_q;
   assign form_y     = y_q;
   assign dir        = dir_q;
   assign step_pulse = pulse_q;
   assign landed     = landed_q;
   assign cleared    = cleared_q;
   assign busy       = (state_q == StMarch);

endmodule

// File: tb/tb_monster_march_ctrl.sv
// Bench for monster_march_ctrl: directed scenarios plus randomized traffic, every cycle
// compared against a behavioural model of the formation.
module tb_monster_march_ctrl;

   logic       clk;
   logic       rst;
   logic       start;
   logic [2:0] level_in;
   logic       frame_tick;
   logic       freeze;
   logic [7:0] alive_mask;
   logic [9:0] form_x, form_y;
   logic       dir, step_pulse, landed, cleared, busy;

   int n_checks;
   int n_errors;

   // Model state: mode 0 idle, 1 load, 2 march, 3 halt
   int m_mode, m_x, m_y, m_dir, m_cnt, m_base, m_pulse, m_landed, m_cleared;

   monster_march_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .level_in   (level_in),
      .frame_tick (frame_tick),
      .freeze     (freeze),
      .alive_mask (alive_mask),
      .form_x     (form_x),
      .form_y     (form_y),
      .dir        (dir),
      .step_pulse (step_pulse),
      .landed     (landed),
      .cleared    (cleared),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_x = 160; m_y = 75; m_dir = 0; m_cnt = 0; m_base = 30;
      m_pulse = 0; m_landed = 0; m_cleared = 0;
   endtask

   // One clock edge of the reference behaviour.
   task automatic model_edge();
      int period, left, right, px;
      if (rst) begin
         model_reset();
      end else begin
         m_pulse = 0;
         if (start) begin
            m_mode = 1; m_x = 160; m_y = 75; m_dir = 0; m_cnt = 0;
            m_landed = 0; m_cleared = 0;
            m_base = (level_in == 3'd2) ? 15 : 30;
         end else if (m_mode == 1) begin
            m_mode = 2;
         end else if (m_mode == 2) begin
            if (alive_mask == 8'h00) begin
               m_cleared = 1; m_mode = 3;
            end else if (m_y >= 400) begin
               m_landed = 1; m_mode = 3;
            end else if (frame_tick && !freeze) begin
               period = m_base - (8 - $countones(alive_mask));
               if (period < 2) period = 2;
               if (m_cnt >= period - 1) begin
                  m_cnt = 0;
                  m_pulse = 1;
                  left = 1 << 20;
                  right = -1;
                  for (int i = 0; i < 8; i++) begin
                     if (alive_mask[i]) begin
                        px = m_x + i * 40;
                        if (px < left) left = px;
                        if (px + 31 > right) right = px + 31;
                     end
                  end
                  if ((m_dir == 0 && right + 4 > 783) || (m_dir == 1 && left < 148)) begin
                     m_y = m_y + 16;
                     m_dir = 1 - m_dir;
                  end else begin
                     m_x = (m_dir == 0) ? m_x + 4 : m_x - 4;
                  end
               end else begin
                  m_cnt++;
               end
            end
         end
      end
   endtask

   task automatic compare_all();
      check_val("form_x", int'(form_x), m_x);
      check_val("form_y", int'(form_y), m_y);
      check_val("dir", int'(dir), m_dir);
      check_val("step_pulse", int'(step_pulse), m_pulse);
      check_val("landed", int'(landed), m_landed);
      check_val("cleared", int'(cleared), m_cleared);
      check_val("busy", int'(busy), (m_mode == 2) ? 1 : 0);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic do_start(input int lvl, input logic [7:0] mask);
      level_in = 3'(lvl);
      alive_mask = mask;
      frame_tick = 1'b0;
      start = 1'b1;
      cycle();
      start = 1'b0;
      cycle();
   endtask

   // Tick every cycle until a step pulse shows; n = ticks applied.
   task automatic tick_until_pulse(output int n);
      n = 0;
      frame_tick = 1'b1;
      for (int k = 0; k < 200; k++) begin
         cycle();
         n++;
         if (step_pulse) break;
      end
      frame_tick = 1'b0;
      check_val("step_seen", int'(step_pulse), 1);
   endtask

   initial begin
      int n, descents, prev_y, sx, sy;
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1; start = 1'b0; level_in = 3'd1; frame_tick = 1'b0; freeze = 1'b0;
      alive_mask = 8'hFF;
      model_reset();
      #1;
      compare_all();
      cycle();
      cycle();
      rst = 1'b0;
      cycle();

      // 1: level 1, full formation, step after 30 ticks
      do_start(1, 8'hFF);
      tick_until_pulse(n);
      check_val("t1_ticks", n, 30);
      check_val("t1_x", int'(form_x), 164);
      check_val("t1_y", int'(form_y), 75);

      // 2: four dead columns give period 26, then clear mid-count
      do_start(1, 8'h0F);
      tick_until_pulse(n);
      check_val("t2_ticks", n, 26);
      frame_tick = 1'b1;
      repeat (10) cycle();
      alive_mask = 8'h00;
      cycle();
      check_val("t2_cleared", int'(cleared), 1);
      check_val("t2_busy", int'(busy), 0);
      check_val("t2_x", int'(form_x), 164);
      repeat (5) cycle();
      frame_tick = 1'b0;

      // 3: level 2 sweep to right edge
      do_start(2, 8'hFF);
      for (int s = 0; s < 78; s++) tick_until_pulse(n);
      check_val("t3_x78", int'(form_x), 472);
      tick_until_pulse(n);
      check_val("t3_x79", int'(form_x), 472);
      check_val("t3_y79", int'(form_y), 91);
      check_val("t3_dir79", int'(dir), 1);
      tick_until_pulse(n);
      check_val("t3_x80", int'(form_x), 468);

      // 4: left edge with column 0 dead
      alive_mask = 8'hFE;
      for (int s = 0; s < 200; s++) begin
         if (form_x == 10'd112) break;
         tick_until_pulse(n);
      end
      check_val("t4_x112", int'(form_x), 112);
      tick_until_pulse(n);
      check_val("t4_x108", int'(form_x), 108);
      tick_until_pulse(n);
      check_val("t4_x104", int'(form_x), 104);
      tick_until_pulse(n);
      check_val("t4_desc_x", int'(form_x), 104);
      check_val("t4_desc_y", int'(form_y), 107);
      check_val("t4_desc_dir", int'(dir), 0);

      // 5: descend until landed
      do_start(2, 8'h81);
      descents = 0;
      prev_y = int'(form_y);
      frame_tick = 1'b1;
      for (int k = 0; k < 30000; k++) begin
         cycle();
         if (int'(form_y) != prev_y) descents++;
         prev_y = int'(form_y);
         if (landed) break;
      end
      check_val("t5_landed", int'(landed), 1);
      check_val("t5_descents", descents, 21);
      check_val("t5_y", int'(form_y), 411);
      check_val("t5_busy", int'(busy), 0);
      sx = int'(form_x);
      sy = int'(form_y);
      repeat (60) cycle();
      check_val("t5_hold_x", int'(form_x), sx);
      check_val("t5_hold_y", int'(form_y), sy);
      frame_tick = 1'b0;

      // 6: start while frozen mid-march, then async reset mid-count
      do_start(1, 8'hFF);
      frame_tick = 1'b1;
      for (int s = 0; s < 3; s++) tick_until_pulse(n);
      frame_tick = 1'b1;
      repeat (10) cycle();
      freeze = 1'b1;
      repeat (5) cycle();
      start = 1'b1;
      cycle();
      start = 1'b0;
      check_val("t6_x", int'(form_x), 160);
      check_val("t6_pulse", int'(step_pulse), 0);
      repeat (40) cycle();
      freeze = 1'b0;
      repeat (12) cycle();
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      compare_all();
      check_val("t6_rst_busy", int'(busy), 0);
      cycle();
      rst = 1'b0;
      frame_tick = 1'b0;
      cycle();

      // Randomized traffic
      do_start(1, 8'hFF);
      for (int k = 0; k < 4000; k++) begin
         frame_tick = 1'($urandom_range(0, 1));
         freeze = ($urandom_range(0, 9) == 0);
         start = ($urandom_range(0, 149) == 0);
         level_in = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 39) == 0) begin
            alive_mask = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
         end
         rst = ($urandom_range(0, 799) == 0);
         cycle();
      end
      rst = 1'b0;
      start = 1'b0;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/monster_march_ctrl.md
Name: monster_march_ctrl

Overview:
Sequences the monster formation for the game datapath. It owns the formation's X/Y origin and march direction, and times each step from a per-frame tick. At the screen edges it drops the formation one row and reverses direction. It speeds up as columns are destroyed and flags landing or a cleared formation to the game state machine. The block sits between the game state machine (level, start) and the rendering/collision block controller, which supplies the alive-column mask and consumes the formation origin.

Parameters:
COLS, 8, number of monster columns
COL_W, 40, column pitch in pixels
MON_W, 32, monster sprite width in pixels
X_MIN, 144, first visible hCount
X_MAX, 783, last visible hCount
X_START, 160, formation origin X after load
Y_START, 75, formation origin Y after load
STEP_X, 4, horizontal pixels per step
STEP_Y, 16, vertical pixels per descent
Y_LIMIT, 400, form_y at or above this value means landed
PERIOD_L1, 30, frames per step at level 1
PERIOD_L2, 15, frames per step at level 2
MIN_PERIOD, 2, lower clamp on the step period

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse: load formation for level_in
level_in  in  3  current level (1, 2; any other value uses PERIOD_L1)
frame_tick  in  1  one-cycle pulse once per video frame
freeze  in  1  hold frame counter and position
alive_mask  in  COLS  bit i=1 when column i has at least one live monster
form_x  out  10  formation origin X (left pixel of column 0)
form_y  out  10  formation origin Y
dir  out  1  0=moving right, 1=moving left
step_pulse  out  1  one-cycle pulse after each position update
landed  out  1  formation reached Y_LIMIT (sticky)
cleared  out  1  alive_mask became zero while marching (sticky)
busy  out  1  high in MARCH

Behaviour:
- Reset values (async, rst=1): state IDLE, form_x=X_START, form_y=Y_START, dir=0, frame_cnt=0, step_pulse=0, landed=0, cleared=0, busy=0.
- States:
  - IDLE: wait for start.
  - LOAD: one cycle. form_x=X_START, form_y=Y_START, dir=0, frame_cnt=0, landed=0, cleared=0, base period latched from level_in. Always goes to MARCH next.
  - MARCH: stepping. busy=1.
  - HALT: position frozen, landed/cleared held.
- start has top priority and moves any state to LOAD on the next edge, including a start received in the middle of MARCH.
- Period in MARCH: period = base − dead, where dead = COLS − popcount(alive_mask). The result is clamped to at least MIN_PERIOD and is recomputed every cycle.
- Frame counter:
  - Advances on frame_tick when freeze=0.
  - On a frame_tick where frame_cnt ≥ period−1, the step executes on that edge and frame_cnt returns to 0. The ≥ comparison covers a period that shrinks mid-count.
  - step_pulse is high the cycle after the update.
- Step computation (11-bit unsigned internally, no wrap):
  - lcol/rcol are the lowest/highest set bit of alive_mask.
  - left_px = form_x + lcol·COL_W.
  - right_px = form_x + rcol·COL_W + MON_W − 1.
  - dir=0: if right_px + STEP_X > X_MAX, descend; else form_x += STEP_X.
  - dir=1: if left_px < X_MIN + STEP_X, descend; else form_x −= STEP_X.
  - Descend: form_y += STEP_Y, dir toggles, form_x unchanged.
- Termination, evaluated every cycle in MARCH:
  - alive_mask==0: cleared=1, go to HALT, no further steps.
  - Otherwise, form_y ≥ Y_LIMIT (checked the cycle after a descent): landed=1, go to HALT.
  - If both conditions are true in the same cycle, cleared wins.
- freeze=1: ticks are ignored and the counter holds. The termination checks still run.
- frame_tick in IDLE, LOAD or HALT has no effect.

Test Plan:
1. rst, start with level_in=1, alive_mask=0xFF → 30 frame_ticks, then step_pulse once; form_x=164, form_y=75, dir=0.
2. Level 1, alive_mask=0x0F → period 26; first step_pulse on tick 26. Change mask to 0x00 mid-count → cleared=1 and busy=0 next cycle; form_x unchanged.
3. Level 2, mask 0xFF, 78 steps → form_x=472 (right_px 783). Step 79 → form_x=472, form_y=91, dir=1. Following step → form_x=468.
4. Mask 0xFE while dir=1, form_x=112 → left_px 152, step moves form_x to 108. At form_x=104 (left_px 144 < 148), the next step descends.
5. Repeated descents from Y_START → after the 21st descent form_y=411, landed=1, HALT; further frame_ticks leave form_x/form_y unchanged.
6. Start asserted mid-MARCH with freeze=1 held, then rst pulsed mid-count → outputs return to load/reset values within one cycle; step_pulse=0.
